// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ID/EX control word and its bubble value.
package pipeline_pkg;

  // Decoded control word carried from decode into execute.
  // The ALU code is only transported here, never interpreted.
  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src;
    logic [1:0] result_src;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
    logic       valid;
  } id_ex_ctrl_t;

  localparam int unsigned ID_EX_CTRL_W = $bits(id_ex_ctrl_t);

  // A bubble is an all-zero control word: no side effects, not valid.
  localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_reg.sv
// Generic pipeline register with enable, synchronous clear and async reset.
module pipeline_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset clears; otherwise when enabled, load zero on clr or capture d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall/flush handling and a saturating bubble counter.
module id_ex_register
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned BCNT_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_e_i,
  input  logic              flush_e_i,
  input  logic              valid_d_i,
  input  logic [3:0]        alu_control_d_i,
  input  logic              alu_src_d_i,
  input  logic [1:0]        result_src_d_i,
  input  logic              reg_write_d_i,
  input  logic              mem_write_d_i,
  input  logic              branch_d_i,
  input  logic              jump_d_i,
  input  logic [2:0]        funct3_d_i,
  input  logic [XLEN-1:0]   rd1_d_i,
  input  logic [XLEN-1:0]   rd2_d_i,
  input  logic [XLEN-1:0]   pc_d_i,
  input  logic [XLEN-1:0]   pc_plus4_d_i,
  input  logic [XLEN-1:0]   imm_ext_d_i,
  input  logic [4:0]        rs1_d_i,
  input  logic [4:0]        rs2_d_i,
  input  logic [4:0]        rd_d_i,
  output logic              valid_e_o,
  output logic [3:0]        alu_control_e_o,
  output logic              alu_src_e_o,
  output logic [1:0]        result_src_e_o,
  output logic              reg_write_e_o,
  output logic              mem_write_e_o,
  output logic              branch_e_o,
  output logic              jump_e_o,
  output logic [2:0]        funct3_e_o,
  output logic [XLEN-1:0]   rd1_e_o,
  output logic [XLEN-1:0]   rd2_e_o,
  output logic [XLEN-1:0]   pc_e_o,
  output logic [XLEN-1:0]   pc_plus4_e_o,
  output logic [XLEN-1:0]   imm_ext_e_o,
  output logic [4:0]        rs1_e_o,
  output logic [4:0]        rs2_e_o,
  output logic [4:0]        rd_e_o,
  output logic [BCNT_W-1:0] bubble_count_o
);

  localparam int unsigned DATA_W = 5 * XLEN + 15;

  id_ex_ctrl_t       ctrl_d;
  id_ex_ctrl_t       ctrl_e;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_e;
  logic              load_en;
  logic              ctrl_clr;
  logic              data_clr;
  logic              bubble;

  // Flush overrides stall, so the registers advance on flush or when not stalled.
  // The clear inputs only take effect when the register is enabled, so an
  // invalid instruction sitting under a stall does not disturb the held word.
  assign load_en  = flush_e_i | ~stall_e_i;
  assign ctrl_clr = flush_e_i | ~valid_d_i;
  assign data_clr = flush_e_i;
  assign bubble   = flush_e_i | (~stall_e_i & ~valid_d_i);

  // Assemble the incoming control word from the decode-stage strobes.
  always_comb begin
    ctrl_d             = ID_EX_CTRL_BUBBLE;
    ctrl_d.alu_control = alu_control_d_i;
    ctrl_d.alu_src     = alu_src_d_i;
    ctrl_d.result_src  = result_src_d_i;
    ctrl_d.reg_write   = reg_write_d_i;
    ctrl_d.mem_write   = mem_write_d_i;
    ctrl_d.branch      = branch_d_i;
    ctrl_d.jump        = jump_d_i;
    ctrl_d.funct3      = funct3_d_i;
    ctrl_d.valid       = valid_d_i;
  end

  assign data_d = {rd1_d_i, rd2_d_i, pc_d_i, pc_plus4_d_i, imm_ext_d_i,
                   rs1_d_i, rs2_d_i, rd_d_i};

  pipeline_reg #(
    .WIDTH (ID_EX_CTRL_W)
  ) u_ctrl_reg (
    .clk (clk_i),
    .rst (reset_i),
    .en  (load_en),
    .clr (ctrl_clr),
    .d   (ctrl_d),
    .q   (ctrl_e)
  );

  pipeline_reg #(
    .WIDTH (DATA_W)
  ) u_data_reg (
    .clk (clk_i),
    .rst (reset_i),
    .en  (load_en),
    .clr (data_clr),
    .d   (data_d),
    .q   (data_e)
  );

  // Count bubbles entering execute, saturating at all-ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bubble_count_o <= '0;
    end else if (bubble && (bubble_count_o != '1)) begin
      bubble_count_o <= bubble_count_o + BCNT_W'(1);
    end
  end

  assign valid_e_o       = ctrl_e.valid;
  assign alu_control_e_o = ctrl_e.alu_control;
  assign alu_src_e_o     = ctrl_e.alu_src;
  assign result_src_e_o  = ctrl_e.result_src;
  assign reg_write_e_o   = ctrl_e.reg_write;
  assign mem_write_e_o   = ctrl_e.mem_write;
  assign branch_e_o      = ctrl_e.branch;
  assign jump_e_o        = ctrl_e.jump;
  assign funct3_e_o      = ctrl_e.funct3;

  assign {rd1_e_o, rd2_e_o, pc_e_o, pc_plus4_e_o, imm_ext_e_o,
          rs1_e_o, rs2_e_o, rd_e_o} = data_e;

endmodule
